wb_regfile: RTL

- Writeback end of the five-stage Y86-64 pipeline. Consumes the W-stage pipeline register outputs and commits W_valE/W_valM into a 15-entry 64-bit register file.
- Serves the two decode-stage read ports.
- Holds the architectural program status (Stat) as a sticky run/stop state machine.
- Counts retired instructions for performance debug.

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/regfile_2r2w.sv | 32 +++
 rtl/wb_regfile.sv | 83 ++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, register and icode IDs, writeback
// payload types.
package y86_pkg;

  localparam int unsigned NREG = 15;
  localparam int unsigned CNTW = 32;
  localparam int unsigned XLEN = 64;
  localparam int unsigned RIDW = 4;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [RIDW-1:0] RNONE = 4'hF;
  localparam logic [RIDW-1:0] RRSP  = 4'h4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } wb_state_e;

  // One register-file write request: destination ID plus data.
  typedef struct packed {
    logic [RIDW-1:0] dst;
    logic [XLEN-1:0] val;
  } wr_req_t;

endpackage

// File: rtl/regfile_2r2w.sv
// 15x64 register file: two combinational read ports, two write ports where
// port M overrides port E on a shared destination.
module regfile_2r2w
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  wr_req_t         wr_e,
  input  wr_req_t         wr_m,
  input  logic [RIDW-1:0] src_a,
  input  logic [RIDW-1:0] src_b,
  output logic [XLEN-1:0] rval_a,
  output logic [XLEN-1:0] rval_b
);

  logic [XLEN-1:0] rf [NREG];

  // Port M is written last so it wins when both target the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we) begin
      if (wr_e.dst != RNONE) rf[wr_e.dst] <= wr_e.val;
      if (wr_m.dst != RNONE) rf[wr_m.dst] <= wr_m.val;
    end
  end

  assign rval_a = (src_a == RNONE) ? '0 : rf[src_a];
  assign rval_b = (src_b == RNONE) ? '0 : rf[src_b];

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: commits W-stage results, serves decode reads, keeps
// the sticky program status and the retired-instruction counter.
module wb_regfile
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            W_stall,
  input  logic [1:0]      W_stat,
  input  logic [3:0]      W_icode,
  input  logic [XLEN-1:0] W_valE,
  input  logic [XLEN-1:0] W_valM,
  input  logic [RIDW-1:0] W_dstE,
  input  logic [RIDW-1:0] W_dstM,
  input  logic [RIDW-1:0] d_srcA,
  input  logic [RIDW-1:0] d_srcB,
  output logic [XLEN-1:0] d_rvalA,
  output logic [XLEN-1:0] d_rvalB,
  output logic [1:0]      Stat,
  output logic            halted,
  output logic [CNTW-1:0] retired_count
);

  wb_state_e       state_q;
  logic [1:0]      stat_q;
  logic            halted_q;
  logic [CNTW-1:0] cnt_q;

  logic    commit_c;
  logic    stop_c;
  wr_req_t wr_e_c;
  wr_req_t wr_m_c;

  assign commit_c = (state_q == ST_RUN) && !W_stall && (W_stat == STAT_AOK);
  assign stop_c   = (state_q == ST_RUN) && !W_stall && (W_stat != STAT_AOK);
  assign wr_e_c   = '{dst: W_dstE, val: W_valE};
  assign wr_m_c   = '{dst: W_dstM, val: W_valM};

  regfile_2r2w u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (commit_c),
    .wr_e   (wr_e_c),
    .wr_m   (wr_m_c),
    .src_a  (d_srcA),
    .src_b  (d_srcB),
    .rval_a (d_rvalA),
    .rval_b (d_rvalB)
  );

  // Status FSM and retire counter; STOPPED holds everything until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stop_c) begin
            state_q  <= ST_STOPPED;
            stat_q   <= W_stat;
            halted_q <= 1'b1;
            if (W_stat == STAT_HLT) cnt_q <= cnt_q + CNTW'(1);
          end else if (commit_c && (W_icode != INOP)) begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        ST_STOPPED: begin
          state_q  <= ST_STOPPED;
          halted_q <= 1'b1;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign Stat          = stat_q;
  assign halted        = halted_q;
  assign retired_count = cnt_q;

endmodule
